kamacore_muldiv_ctrl: RTL and testbench
=======================================

KAMACORE_MULDIV_CTRL -- requirements
Module: kamacore_muldiv_ctrl

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  EX-stage request; the instruction in ID/EX is RV32M.
REQ-005 SHALL have port funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port op_a  input  CPU_WIDTH  rs1 value after forwarding.
REQ-007 SHALL have port op_b  input  CPU_WIDTH  rs2 value after forwarding.
REQ-008 SHALL have port flush  input  1  pipeline kill; aborts the operation in flight.
REQ-009 SHALL have port stall  output  1  holds IF/ID/EX stage buffers.
REQ-010 SHALL have port busy  output  1  iteration in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-012 SHALL have port result  output  CPU_WIDTH  selected product/quotient/remainder.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-014 IDLE: start=1 and flush=0 in cycle T SHALL latch the operands, abs values, sign flags and funct3, then move to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-015 MUL SHALL run a 32-iteration shift-add on magnitudes into a 64-bit accumulator, one bit per cycle; busy high T+1..T+32; DONE at T+33.
REQ-016 DIV SHALL run a 32-iteration restoring divide on magnitudes, one quotient bit per cycle; same timing as REQ-015.
REQ-017 Divide by zero SHALL skip iteration: DIV/DIVU quotient all ones, REM/REMU remainder = op_a; DONE at T+2.
REQ-018 Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000, remainder 0; DONE at T+2.
REQ-019 Signs: MUL/MULH both signed, MULHSU op_a signed only, MULHU/DIVU/REMU unsigned; product negated if signs differ; quotient negated if signs differ; remainder takes dividend sign.
REQ-020 result SHALL be product[31:0] for MUL, product[63:32] for MULH*, quotient for DIV*, remainder for REM*.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE; result SHALL hold until the next accepted start.
REQ-022 stall SHALL equal (IDLE and start and not flush) or state in {MUL, DIV}; stall=0 in DONE so the pipeline advances with result.
REQ-023 start SHALL be ignored outside IDLE; start in the DONE cycle SHALL NOT be accepted.
REQ-024 flush in any state SHALL force IDLE next cycle, done=0, result unchanged; flush wins over simultaneous start.
REQ-025 Iteration counter SHALL be 6 bits, count 0..31, no wrap beyond 31.

Reset
REQ-026 rst=1 at a clock edge SHALL set state IDLE, busy 0, done 0, stall 0 (from next cycle), result 0, accumulators and counter 0.
REQ-027 rst mid-operation SHALL abort without a done pulse; rst SHALL dominate start and flush.

Configuration
REQ-028 Macro KAMACORE_MUL_FAST_EN defined: MUL* SHALL compute the 64-bit product combinationally, go directly IDLE->DONE, done at T+1, stall only in cycle T.
REQ-029 KAMACORE_MUL_FAST_EN undefined: MUL* SHALL use the iterative path of REQ-015; DIV timing unaffected in both builds.

Verification
REQ-030 MUL 7 x -3 (0x00000007, 0xFFFFFFFD), start at T -> done at T+33, result 0xFFFFFFEB; with the fast macro, T+1.
REQ-031 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14 at T+33.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000, each done at T+2.
REQ-034 flush at T+10 of a DIV -> IDLE at T+11, no done, stall low, result unchanged; start+flush together -> not accepted.
REQ-035 rst at T+5 of a MUL -> result 0, busy 0, no done; start in DONE cycle ignored, re-accepted one cycle later.

Source files
------------

// File: rtl/kamacore_muldiv_ctrl.sv
// kamacore_muldiv_ctrl: RV32M multiply/divide sequencer for the EX stage.
// Iterative shift-add multiply and restoring divide on operand magnitudes,
// with sign fix-up applied to the final value and written to result.
// Build option: define KAMACORE_MUL_FAST_EN to compute MUL* combinationally
// in a single cycle (IDLE->DONE); DIV* stays iterative in both builds.
module kamacore_muldiv_ctrl #(
    parameter int CPU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           funct3,
    input  logic [CPU_WIDTH-1:0] op_a,
    input  logic [CPU_WIDTH-1:0] op_b,
    input  logic                 flush,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [CPU_WIDTH-1:0] result
);
    localparam int W = CPU_WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t         state;
    logic [5:0]     cnt;
    logic [1:0]     f3;        // low funct3 bits pick low/high product and quo/rem
    logic [W-1:0]   a_raw;     // dividend as issued, returned as REM on divide by zero
    logic [W-1:0]   mcand;     // multiplicand magnitude (MUL) or divisor magnitude (DIV)
    logic [W-1:0]   acc_hi;    // product high half / partial remainder
    logic [W-1:0]   acc_lo;    // multiplier bits / dividend shifting into quotient
    logic           a_neg, b_neg, div_zero, div_ovf;

    // Operand decode at issue: which operands are signed, their magnitudes
    logic           a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic [W-1:0]   a_mag_in, b_mag_in;
    always_comb begin
        a_signed_in = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        b_signed_in = a_signed_in && (funct3 != 3'b010);
        a_neg_in    = a_signed_in && op_a[W-1];
        b_neg_in    = b_signed_in && op_b[W-1];
        a_mag_in    = a_neg_in ? -op_a : op_a;
        b_mag_in    = b_neg_in ? -op_b : op_b;
    end

    // One iteration step for each datapath, plus the sign-corrected final values
    logic [W:0]     mul_sum, div_sh, div_diff;
    logic           div_ge;
    logic [W-1:0]   mul_hi, mul_lo, div_hi, div_lo, quo_s, rem_s;
    logic [2*W-1:0] prod, prod_s;
    logic [W-1:0]   mul_res, div_res, div_spec;
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        mul_hi   = mul_sum[W:1];
        mul_lo   = {mul_sum[0], acc_lo[W-1:1]};
        div_sh   = {acc_hi, acc_lo[W-1]};
        div_diff = div_sh - {1'b0, mcand};
        div_ge   = ~div_diff[W];
        div_hi   = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
        div_lo   = {acc_lo[W-2:0], div_ge};
        prod     = {mul_hi, mul_lo};
        prod_s   = (a_neg ^ b_neg) ? -prod : prod;
        mul_res  = (f3 == 2'b00) ? prod_s[W-1:0] : prod_s[2*W-1:W];
        quo_s    = (a_neg ^ b_neg) ? -div_lo : div_lo;
        rem_s    = a_neg ? -div_hi : div_hi;
        div_res  = f3[1] ? rem_s : quo_s;
        // Divide by zero wins; overflow only possible with op_b = -1 so never overlaps
        if (div_zero) div_spec = f3[1] ? a_raw : '1;
        else          div_spec = f3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

`ifdef KAMACORE_MUL_FAST_EN
    // Single-cycle product straight from the issue operands
    logic [2*W-1:0] fprod, fprod_s;
    logic [W-1:0]   fast_res;
    always_comb begin
        fprod    = {{W{1'b0}}, a_mag_in} * {{W{1'b0}}, b_mag_in};
        fprod_s  = (a_neg_in ^ b_neg_in) ? -fprod : fprod;
        fast_res = (funct3[1:0] == 2'b00) ? fprod_s[W-1:0] : fprod_s[2*W-1:W];
    end
`endif

    // Hold the pipeline while a request is being accepted or iterating
    assign stall = ((state == IDLE) && start && !flush) || (state == MUL) || (state == DIV);

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cnt      <= '0;
            f3       <= '0;
            a_raw    <= '0;
            mcand    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            a_neg    <= 1'b0;
            b_neg    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt      <= '0;
                        f3       <= funct3[1:0];
                        a_raw    <= op_a;
                        a_neg    <= a_neg_in;
                        b_neg    <= b_neg_in;
                        acc_hi   <= '0;
                        div_zero <= (op_b == '0);
                        div_ovf  <= !funct3[0] && (op_a == {1'b1, {(W-1){1'b0}}}) && (op_b == '1);
                        if (funct3[2]) begin
                            state  <= DIV;
                            busy   <= 1'b1;
                            acc_lo <= a_mag_in;
                            mcand  <= b_mag_in;
                        end else begin
`ifdef KAMACORE_MUL_FAST_EN
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= DONE;
`else
                            state  <= MUL;
                            busy   <= 1'b1;
                            acc_lo <= b_mag_in;
                            mcand  <= a_mag_in;
`endif
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi;
                    acc_lo <= mul_lo;
                    if (cnt == 6'(W-1)) begin
                        result <= mul_res;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DIV: begin
                    if (div_zero || div_ovf) begin
                        result <= div_spec;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        acc_hi <= div_hi;
                        acc_lo <= div_lo;
                        if (cnt == 6'(W-1)) begin
                            result <= div_res;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_kamacore_muldiv_ctrl.sv
// Self-checking bench for kamacore_muldiv_ctrl: directed RV32M cases plus
// randomized operations scored against an arithmetic reference model.
// Honours KAMACORE_MUL_FAST_EN for the expected MUL latency.
module tb_kamacore_muldiv_ctrl;
    logic        clk, rst, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, busy, done;
    logic [31:0] result;

    int errs   = 0;
    int checks = 0;

    kamacore_muldiv_ctrl #(.CPU_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result straight from the RV32M arithmetic definitions
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        ia  = int'(a);
        ib  = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (!f[2]) begin
            sa = (f != 3'd3) ? longint'(ia) : longint'({32'h0, a});
            sb = (f <= 3'd1) ? longint'(ib) : longint'({32'h0, b});
            p  = 64'(sa * sb);
            return (f == 3'd0) ? p[31:0] : p[63:32];
        end
        case (f)
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the start cycle to the done cycle
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) begin
`ifdef KAMACORE_MUL_FAST_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 2;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Poll for done after acceptance; optionally scramble inputs while busy
    task automatic wait_done(input bit junk, input bit exp_busy, output int lat, output logic [31:0] res);
        lat = -1;
        res = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_after_start", busy, exp_busy);
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            if (junk) begin
                start  = 1'($urandom);
                funct3 = 3'($urandom);
                op_a   = $urandom;
                op_b   = $urandom;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit junk);
        int lat;
        logic [31:0] res, exp;
        exp = ref_res(f, a, b);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1 chk("stall_start_cycle", stall, 1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(junk, ref_lat(f, a, b) != 1, lat, res);
        start = 1'b0;
        chk("latency", 64'(lat), 64'(ref_lat(f, a, b)));
        chk("result", res, exp);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("result_hold", result, exp);
    endtask

    task automatic no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(tag, 64'(seen), 0);
    endtask

    initial begin
        int lat;
        logic [31:0] res, held;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_stall", stall, 0);
        rst = 1'b0;

        // Directed arithmetic cases
        do_op(3'd0, 32'h7, 32'hFFFF_FFFD, 0);          // MUL 7 x -3
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);  // MULHU
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);  // MULH
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);  // MULHSU
        do_op(3'd4, 32'hFFFF_FFF9, 32'h2, 0);          // DIV -7/2
        do_op(3'd6, 32'hFFFF_FFF9, 32'h2, 0);          // REM -7/2
        do_op(3'd5, 32'd100, 32'd7, 0);                // DIVU 100/7
        do_op(3'd5, 32'd5, 32'd0, 0);                  // DIVU by zero
        do_op(3'd6, 32'd5, 32'd0, 0);                  // REM by zero
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);  // DIV overflow
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);  // REM overflow

        // Flush during a divide at T+10
        held = result;
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        #1 chk("flush_stall", stall, 0);
        chk("flush_result", result, held);
        no_done("flush_no_done", 40);

        // Start together with flush is not accepted
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd9; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        #1 chk("startflush_stall", stall, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("startflush_busy", busy, 0);
        no_done("startflush_no_done", 40);

        // Reset at T+5 of a multiply
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_result", result, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        no_done("rstmid_no_done", 40);

        // Start presented in the DONE cycle waits one cycle
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, 1, lat, res);
        chk("chain_first_result", res, 32'd14);
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        #1 chk("chain_done_stall", stall, 0);
        @(negedge clk);
        chk("chain_idle_busy", busy, 0);
        chk("chain_idle_stall", stall, 1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(0, ref_lat(3'd0, 32'd3, 32'd5) != 1, lat, res);
        chk("chain_latency", 64'(lat), 64'(ref_lat(3'd0, 32'd3, 32'd5)));
        chk("chain_result", res, 32'd15);

        // Randomized operations with junk inputs while busy
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom), pick(), pick(), 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
